// File: rtl/dmem_arbiter.sv
// Shared data-memory arbiter between the core load/store port and the debug/loader port.
// One access at a time through IDLE -> ISSUE -> CAPTURE -> DONE, round-robin on contention.
module dmem_arbiter #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  core_req,
  input  logic                  core_we,
  input  logic [ADDR_WIDTH-1:0] core_addr,
  input  logic [DATA_WIDTH-1:0] core_wdata,
  output logic [DATA_WIDTH-1:0] core_rdata,
  output logic                  core_ready,
  input  logic                  dbg_req,
  input  logic                  dbg_we,
  input  logic [ADDR_WIDTH-1:0] dbg_addr,
  input  logic [DATA_WIDTH-1:0] dbg_wdata,
  output logic [DATA_WIDTH-1:0] dbg_rdata,
  output logic                  dbg_ack,
  input  logic                  dbg_halt,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic [CNT_WIDTH-1:0]  stall_cnt
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ISSUE   = 2'd1;
  localparam logic [1:0] S_CAPTURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  localparam logic OWN_CORE = 1'b0;
  localparam logic OWN_DBG  = 1'b1;

  typedef struct packed {
    logic                  we;
    logic [ADDR_WIDTH-1:0] addr;
    logic [DATA_WIDTH-1:0] wdata;
  } acc_req_t;

  logic [1:0] state;
  logic       owner;
  logic       last;
  acc_req_t   req_q;

  logic       core_elig;
  logic       dbg_elig;
  logic       grant;
  logic       win;
  acc_req_t   win_req;

  // Under contention the side that did not own the previous access wins.
  always_comb begin
    core_elig = core_req & ~dbg_halt;
    dbg_elig  = dbg_req;
    grant     = (state == S_IDLE) && (core_elig || dbg_elig);
    win       = (core_elig && dbg_elig) ? ~last : dbg_elig;
    win_req   = '0;
    if (win == OWN_DBG) begin
      win_req.we    = dbg_we;
      win_req.addr  = dbg_addr;
      win_req.wdata = dbg_wdata;
    end else begin
      win_req.we    = core_we;
      win_req.addr  = core_addr;
      win_req.wdata = core_wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
      owner <= OWN_CORE;
      last  <= OWN_DBG;
      req_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            state <= S_ISSUE;
            owner <= win;
            last  <= win;
            req_q <= win_req;
          end
        end
        S_ISSUE:   state <= S_CAPTURE;
        S_CAPTURE: state <= S_DONE;
        default:   state <= S_IDLE;
      endcase
    end
  end

  // Only the owner's read-data register is ever written, and only on a load.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      core_rdata <= '0;
      dbg_rdata  <= '0;
    end else if (state == S_CAPTURE && !req_q.we) begin
      if (owner == OWN_DBG) dbg_rdata  <= mem_rdata;
      else                  core_rdata <= mem_rdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (core_req && !core_ready && stall_cnt != {CNT_WIDTH{1'b1}}) begin
      stall_cnt <= stall_cnt + CNT_WIDTH'(1);
    end
  end

  // Decoded from state so reset clears them without waiting for an edge.
  assign mem_en     = (state == S_ISSUE);
  assign mem_we     = req_q.we;
  assign mem_addr   = req_q.addr;
  assign mem_wdata  = req_q.wdata;
  assign core_ready = (state == S_DONE) && (owner == OWN_CORE);
  assign dbg_ack    = (state == S_DONE) && (owner == OWN_DBG);

endmodule
